// File: rtl/uart_rx_deser_if.sv
// rtl/uart_rx_deser_if.sv - RXD/tick/register-strobe bundle between UART pin side, baud generator and RBR/LSR register file
interface uart_rx_deser_if #(
    parameter int DATALEN = 8
);
    logic               baud_tick;
    logic               rxd;
    logic               rbr_rd;
    logic               lsr_rd;
    logic               parity_odd;
    logic [DATALEN-1:0] rx_data;
    logic               data_ready;
    logic               overrun_err;
    logic               framing_err;
    logic               parity_err;
    logic               rx_busy;

    modport master (
        output baud_tick, rxd, rbr_rd, lsr_rd, parity_odd,
        input  rx_data, data_ready, overrun_err, framing_err, parity_err, rx_busy
    );

    modport slave (
        input  baud_tick, rxd, rbr_rd, lsr_rd, parity_odd,
        output rx_data, data_ready, overrun_err, framing_err, parity_err, rx_busy
    );
endinterface

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - UART receive deserializer with RBR holding register and LSR status; optional parity via UART_RX_PARITY_EN
module uart_rx_deser #(
    parameter int OSR     = 16,
    parameter int DATALEN = 8
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_deser_if.slave  bus
);
    localparam int CW = $clog2(OSR);
    localparam int IW = $clog2(DATALEN);
    localparam logic [CW-1:0] HALF_LAST = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OSR - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATALEN - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state, state_nx;
    logic               rxd_m, rxd_s;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [IW-1:0]      idx, idx_nx;
    logic [DATALEN-1:0] shreg, shreg_nx, data_q, data_nx;
    logic               armed, armed_nx;
    logic               dr, dr_nx, oe, oe_nx, fe, fe_nx, pe, pe_nx;
    logic               busy;
    logic               commit;
`ifdef UART_RX_PARITY_EN
    logic               par_bad, par_bad_nx;
`else
    wire                unused_parity_odd = bus.parity_odd;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m  <= 1'b1;
            rxd_s  <= 1'b1;
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            data_q <= '0;
            armed  <= 1'b1;
            dr     <= 1'b0;
            oe     <= 1'b0;
            fe     <= 1'b0;
            pe     <= 1'b0;
            busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            rxd_m  <= bus.rxd;
            rxd_s  <= rxd_m;
            state  <= state_nx;
            cnt    <= cnt_nx;
            idx    <= idx_nx;
            shreg  <= shreg_nx;
            data_q <= data_nx;
            armed  <= armed_nx;
            dr     <= dr_nx;
            oe     <= oe_nx;
            fe     <= fe_nx;
            pe     <= pe_nx;
            busy   <= (state_nx != IDLE);
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shreg_nx = shreg;
        commit   = 1'b0;
        // After a zero stop bit the line must go idle before a new start is accepted (break handling)
        armed_nx = armed | rxd_s;
`ifdef UART_RX_PARITY_EN
        par_bad_nx = par_bad;
`endif
        if (bus.baud_tick) begin
            case (state)
                IDLE: begin
                    if (!rxd_s && armed) begin
                        cnt_nx   = '0;
                        state_nx = START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt_nx   = '0;
                        idx_nx   = '0;
                        state_nx = rxd_s ? IDLE : DATA;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        shreg_nx = {rxd_s, shreg[DATALEN-1:1]};
                        cnt_nx   = '0;
                        idx_nx   = idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (idx == IDX_LAST) state_nx = PARITY;
`else
                        if (idx == IDX_LAST) state_nx = STOP;
`endif
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        par_bad_nx = rxd_s ^ (^shreg) ^ bus.parity_odd;
                        cnt_nx     = '0;
                        state_nx   = STOP;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        commit   = 1'b1;
                        cnt_nx   = '0;
                        state_nx = IDLE;
                        if (!rxd_s) armed_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Status flags: a set event in the same cycle beats the clearing read
    always_comb begin
        data_nx = data_q;
        dr_nx   = dr & ~bus.rbr_rd;
        oe_nx   = oe & ~bus.lsr_rd;
        fe_nx   = fe & ~bus.lsr_rd;
`ifdef UART_RX_PARITY_EN
        pe_nx   = pe & ~bus.lsr_rd;
`else
        pe_nx   = 1'b0;
`endif
        if (commit) begin
            if (!dr || bus.rbr_rd) begin
                data_nx = shreg;
                dr_nx   = 1'b1;
            end else begin
                oe_nx = 1'b1;
            end
            if (!rxd_s) fe_nx = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (par_bad) pe_nx = 1'b1;
`endif
        end
    end

    assign bus.rx_data     = data_q;
    assign bus.data_ready  = dr;
    assign bus.overrun_err = oe;
    assign bus.framing_err = fe;
    assign bus.parity_err  = pe;
    assign bus.rx_busy     = busy;
endmodule
